// File: rtl/decode_s1_rx.sv
// decode_s1_rx: two-entry skid FIFO between decode stage 1 and register read.
// Optional zero-latency bypass when empty: define DECODE_S1_RX_BYPASS_EN.
module decode_s1_rx #(
  parameter int PAYLOADW = 163,
  parameter int STALLW   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                s1_valid,
  output logic                s1_ready,
  input  logic [PAYLOADW-1:0] s1_payload,
  output logic                s2_valid,
  input  logic                s2_ready,
  output logic [PAYLOADW-1:0] s2_payload,
  output logic [1:0]          occupancy,
  output logic [STALLW-1:0]   stall_count,
  input  logic                stall_clear
);

  logic [PAYLOADW-1:0] mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;
  logic                bypass;
  logic                push;
  logic                pop;
  logic                wr_en;
  logic                rd_en;

`ifdef DECODE_S1_RX_BYPASS_EN
  assign bypass = (count == 2'd0) & s1_valid & ~flush & ~reset;
`else
  assign bypass = 1'b0;
`endif

  // Ready looks only at registered state and flush, so s2_ready never reaches decode.
  assign s1_ready   = (count != 2'd2) & ~flush & ~reset;
  assign s2_valid   = ((count != 2'd0) | bypass) & ~flush;
  assign s2_payload = bypass ? s1_payload : mem[rd_ptr];
  assign occupancy  = count;

  assign push  = s1_valid & s1_ready;
  assign pop   = s2_valid & s2_ready;
  // A bypassed bundle that is taken downstream never lands in storage.
  assign wr_en = push & ~(bypass & pop);
  assign rd_en = pop & ~bypass;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s1_payload;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= ~wr_ptr;
      if (rd_en) rd_ptr <= ~rd_ptr;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_clear) begin
      stall_count <= '0;
    end else if (s2_valid & ~s2_ready & ~(&stall_count)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_s1_rx.sv
// Scoreboard bench for decode_s1_rx: driver pushes expected bundles into a queue,
// monitor pops and compares whenever a bundle is taken downstream.
module tb_decode_s1_rx;
  localparam int PW = 163;
  localparam int SW = 16;
  localparam int STALL_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset, flush, s1_valid, s1_ready, s2_valid, s2_ready, stall_clear;
  logic [PW-1:0] s1_payload, s2_payload;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_count;

  always #5 clk = ~clk;

  decode_s1_rx #(.PAYLOADW(PW), .STALLW(SW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_payload(s1_payload),
    .s2_valid(s2_valid), .s2_ready(s2_ready), .s2_payload(s2_payload),
    .occupancy(occupancy), .stall_count(stall_count), .stall_clear(stall_clear)
  );

  logic [PW-1:0] sb_q[$];
  logic [PW-1:0] cur_pl;
  int  m_stall = 0;
  bit  m_ready = 0;
  bit  bypassed = 0;
  bit  accepted = 0;
  bit  done = 0;
  int  n_vec = 0;
  int  n_fail = 0;

  function automatic void check(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [PW-1:0] mk(input logic [31:0] pc);
    logic [PW-1:0] p;
    for (int i = 0; i < PW; i++) p[i] = 1'($urandom_range(0, 1));
    p[32:1] = pc;
    return p;
  endfunction

  // Monitor: reference model of a 2-deep in-order buffer, sampled mid-cycle.
  initial begin : monitor
    bit exp_valid, bp;
    while (1) begin
      @(negedge clk);
      #2;
      if (done) break;
      if (reset) begin
        sb_q.delete();
        m_stall = 0;
      end
      bp = 0;
`ifdef DECODE_S1_RX_BYPASS_EN
      if (sb_q.size() == 0 && s1_valid && !flush && !reset) bp = 1;
`endif
      exp_valid = ((sb_q.size() != 0) || bp) && !flush;
      m_ready   = (sb_q.size() != 2) && !flush && !reset;
      bypassed  = 0;
      check("s1_ready", PW'(s1_ready), PW'(m_ready));
      check("s2_valid", PW'(s2_valid), PW'(exp_valid));
      check("occupancy", PW'(occupancy), PW'(sb_q.size()));
      check("stall_count", PW'(stall_count), PW'(m_stall));
      if (exp_valid && s2_ready) begin
        if (bp) begin
          check("s2_payload_bypass", s2_payload, cur_pl);
          bypassed = 1;
        end else begin
          check("s2_payload", s2_payload, sb_q[0]);
          void'(sb_q.pop_front());
        end
      end
      if (stall_clear) m_stall = 0;
      else if (exp_valid && !s2_ready && m_stall < STALL_MAX) m_stall++;
    end
  end

  task automatic cycle(input bit v, input logic [PW-1:0] pl, input bit rdy,
                       input bit fl, input bit clr, input bit rst);
    @(negedge clk);
    reset = rst; s1_valid = v; s1_payload = pl; cur_pl = pl;
    s2_ready = rdy; flush = fl; stall_clear = clr;
    #3;
    accepted = v && m_ready && !fl && !rst;
    if (fl || rst) sb_q.delete();
    else if (accepted && !bypassed) sb_q.push_back(pl);
  endtask

  task automatic offer(input logic [PW-1:0] pl, input bit rdy);
    int n = 0;
    do begin
      cycle(1, pl, rdy, 0, 0, 0);
      n++;
    end while (!accepted && n < 8);
    n_vec++;
    if (!accepted) begin
      n_fail++;
      $display("FAIL offer_timeout: bundle not accepted after %0d cycles, required acceptance", n);
    end
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [PW-1:0] b0, b1, b2;
    reset = 1; flush = 0; s1_valid = 0; s1_payload = '0; cur_pl = '0;
    s2_ready = 0; stall_clear = 0;
    repeat (3) cycle(0, '0, 0, 0, 0, 1);

    // streaming with downstream always ready
    cycle(1, mk(32'h100), 1, 0, 0, 0);
    cycle(1, mk(32'h104), 1, 0, 0, 0);
    cycle(1, mk(32'h108), 1, 0, 0, 0);
    repeat (2) cycle(0, '0, 1, 0, 0, 0);

    // backpressure: two absorbed, third held upstream
    b0 = mk(32'h200); b1 = mk(32'h204); b2 = mk(32'h208);
    cycle(1, b0, 0, 0, 0, 0);
    cycle(1, b1, 0, 0, 0, 0);
    repeat (3) cycle(1, b2, 0, 0, 0, 0);
    offer(b2, 1);
    repeat (3) cycle(0, '0, 1, 0, 0, 0);

    // count 1 with push and pop every cycle, across pointer wraps
    cycle(1, mk(32'h300), 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, mk(32'h304 + 4 * i), 1, 0, 0, 0);
    repeat (2) cycle(0, '0, 1, 0, 0, 0);

    // flush while full with incoming bundle
    cycle(1, mk(32'h400), 0, 0, 0, 0);
    cycle(1, mk(32'h404), 0, 0, 0, 0);
    cycle(1, mk(32'h408), 1, 1, 0, 0);
    repeat (3) cycle(0, '0, 1, 0, 0, 0);

    // stall counter saturation then clear
    cycle(0, '0, 0, 0, 1, 0);
    cycle(1, mk(32'h500), 0, 0, 0, 0);
    repeat (STALL_MAX + 5) cycle(0, '0, 0, 0, 0, 0);
    cycle(0, '0, 0, 0, 1, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);

    // reset mid-operation
    cycle(1, mk(32'h600), 0, 0, 0, 0);
    cycle(1, mk(32'h604), 0, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 1);
    repeat (3) cycle(0, '0, 1, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 1)), mk($urandom), 1'($urandom_range(0, 2) != 0),
            $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0, 0);

    repeat (4) cycle(0, '0, 1, 0, 0, 0);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d bundles left undelivered, required 0", sb_q.size());
    end
    done = 1;
    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_s1_rx.md
# decode_s1_rx

Receiving end of the decode stage 1 output pipe (`s1_*`): a two-entry skid FIFO that accepts fully decoded instruction bundles from `decode_stage_1` and presents them to the register-read stage (`s2_*`). It breaks the combinational ready path from downstream back into decode, drops in-flight bundles on pipeline flush, and keeps a saturating backpressure counter for performance debug.

## Interface
Parameters:
- `PAYLOADW`, 163, packed bundle width. Order, MSB first: {size[2:0], set_d_flag, clear_d_flag, op0[2:0], op1[2:0], op0_reg[2:0], op1_reg[2:0], modrm[7:0], sib[7:0], imm[47:0], disp[31:0], alu_op[3:0], flag_0[2:0], flag_1[2:0], stack_op[1:0], seg_override[2:0], seg_override_valid, movs, pc[31:0], branch_taken}.
- `STALLW`, 16, stall counter width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  drop all buffered and incoming bundles.
- `s1_valid`  in  1  upstream bundle valid.
- `s1_ready`  out  1  FIFO can accept.
- `s1_payload`  in  PAYLOADW  packed decode bundle.
- `s2_valid`  out  1  bundle available downstream.
- `s2_ready`  in  1  downstream accepts.
- `s2_payload`  out  PAYLOADW  head bundle.
- `occupancy`  out  2  entries held (0..2).
- `stall_count`  out  STALLW  saturating count of backpressure cycles.
- `stall_clear`  in  1  synchronous clear of `stall_count`.

## Operation
- Storage: two PAYLOADW entries, 1-bit write pointer, 1-bit read pointer, 2-bit count. Pointers wrap 1→0.
- Push = `s1_valid & s1_ready`; pop = `s2_valid & s2_ready`.
- `s1_ready = (count != 2) & ~flush & ~reset`. Depends only on registered state and `flush`; never on `s2_ready`.
- `s2_valid = (count != 0) & ~flush`; `s2_payload` = entry[rd_ptr]. Payload held stable while `s2_valid & ~s2_ready`.
- Count update: push only +1; pop only −1; both: unchanged; neither: unchanged.
- Push at count 1 with simultaneous pop: new entry written to wr_ptr, head advances; order preserved.
- Flush: next edge sets count=0, wr_ptr=rd_ptr=0; any push or pop in the flush cycle is discarded. Entry contents need not be cleared.
- `stall_count`: increments each cycle `s2_valid & ~s2_ready`; saturates at all-ones (no wrap). `stall_clear` has priority over increment; flush does not clear it.
- `occupancy` = count.

## Timing
- Reset (async assert): count 0, pointers 0, `s2_valid` 0, `occupancy` 0, `stall_count` 0; `s1_ready` 0 while `reset` high, 1 on first cycle after deassert.
- Latency: bundle pushed at edge N visible on `s2_*` in cycle N+1 (one cycle, no bypass by default).
- Throughput: one bundle per cycle sustained with `s2_ready` high.
- Full (count 2): `s1_ready` low; upstream holds. Empty: `s2_valid` low, `s2_payload` don't-care.
- `s2_ready` dropping while full: no loss; `s1_ready` low next cycle only after count reaches 2 (skid absorbs the one in-flight bundle).
- Reset mid-operation: all state cleared immediately, no bundle emitted after.

## Configuration
- `DECODE_S1_RX_BYPASS_EN`: when defined, with count 0, `s1_valid` high and `flush` low, `s2_valid`=1 and `s2_payload`=`s1_payload` combinationally; if `s2_ready` also high, bundle passes with zero latency and is not written (count stays 0). `s1_ready` remains independent of `s2_ready`. Without the macro, latency is always one cycle and no combinational s1→s2 path exists.

## Test plan
- Reset release, `s2_ready`=1, push pc=0x100,0x104,0x108 on consecutive cycles -> `s2_valid` from next cycle, same pcs in order, one per cycle, `occupancy` ≤1.
- `s2_ready`=0, push 3 bundles -> `s1_ready` falls after 2 accepted, `occupancy`=2, third held upstream; raise `s2_ready` -> all 3 delivered in order, `stall_count` equals stalled cycles.
- Count 1, simultaneous push and pop -> `occupancy` stays 1, head advances, order intact across pointer wrap.
- Count 2, assert `flush` with `s1_valid`=1 -> `s1_ready`=0 and `s2_valid`=0 that cycle; next cycle `occupancy`=0, no stale bundle emitted.
- `stall_count` held at 0xFFFE with continuous backpressure for 5 cycles -> reads 0xFFFF, no wrap; `stall_clear` -> 0.
- With `DECODE_S1_RX_BYPASS_EN`, empty FIFO, `s1_valid`=`s2_ready`=1 -> `s2_payload` equals `s1_payload` same cycle, `occupancy` stays 0.
